// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback controller: result-source
// select, FSM state encoding and load funct3 codes.
package wb_pkg;

  typedef enum logic [1:0] {
    SRC_ALU = 2'b00,
    SRC_MEM = 2'b01,
    SRC_PC4 = 2'b10,
    SRC_IMM = 2'b11
  } wb_src_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_MEM = 2'b01,
    ST_WRITE    = 2'b10
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_unit_load_formatter.sv
// Combinational load formatter: picks the byte/half lane addressed by the
// low address bits and sign- or zero-extends it to XLEN.
module load_formatter
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // NOTE: every output of a combinational block is given a value on every
  // path (default first) so no latch is inferred.
  always_comb begin
    byte_v = mem_rdata_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_v = mem_rdata_i[15:8];
      2'd2:    byte_v = mem_rdata_i[23:16];
      2'd3:    byte_v = mem_rdata_i[31:24];
      default: byte_v = mem_rdata_i[7:0];
    endcase

    half_v = addr_lo_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LH:   data_o = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_v};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_v};
      default: data_o = mem_rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback controller: captures a request, waits for memory on loads and
// issues one registered register-file write beat. Optional memory timeout
// abort is enabled by defining WB_TIMEOUT_EN.
module wb_unit
  import wb_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_req,
  input  logic [4:0]      wb_rd,
  input  logic [1:0]      wb_src,
  input  logic [2:0]      wb_funct3,
  input  logic [1:0]      wb_addr_lo,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid,
  output logic            rf_we,
  output logic [4:0]      rf_a3,
  output logic [XLEN-1:0] rf_wd,
  output logic            busy,
  output logic            done,
  output logic            err
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wb_unit: TIMEOUT_CYCLES must be at least 1");
  end

  state_t          state_q, state_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_a3_q, rf_a3_d;
  logic [XLEN-1:0] rf_wd_q, rf_wd_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] operand;
  logic [XLEN-1:0] load_data;

  load_formatter #(.XLEN(XLEN)) u_fmt (
    .mem_rdata_i (mem_rdata),
    .funct3_i    (funct3_q),
    .addr_lo_i   (addr_lo_q),
    .data_o      (load_data)
  );

  always_comb begin
    case (wb_src_t'(wb_src))
      SRC_PC4: operand = pc_plus4;
      SRC_IMM: operand = imm;
      default: operand = alu_result;
    endcase
  end

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign cnt_d   = (state_q == ST_WAIT_MEM) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  // Outputs are computed one cycle ahead so the write beat leaves a register.
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    funct3_d  = funct3_q;
    addr_lo_d = addr_lo_q;
    rf_we_d   = 1'b0;
    rf_a3_d   = rf_a3_q;
    rf_wd_d   = rf_wd_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wb_req) begin
          rd_d      = wb_rd;
          funct3_d  = wb_funct3;
          addr_lo_d = wb_addr_lo;
          if (wb_src_t'(wb_src) == SRC_MEM) begin
            state_d = ST_WAIT_MEM;
          end else begin
            state_d = ST_WRITE;
            rf_we_d = (wb_rd != 5'd0);
            rf_a3_d = wb_rd;
            rf_wd_d = operand;
            done_d  = 1'b1;
          end
        end
      end
      ST_WAIT_MEM: begin
        if (mem_rvalid) begin
          state_d = ST_WRITE;
          rf_we_d = (rd_q != 5'd0);
          rf_a3_d = rd_q;
          rf_wd_d = load_data;
          done_d  = 1'b1;
        end
`ifdef WB_TIMEOUT_EN
        else if (timeout) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
`endif
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rd_q      <= '0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
      rf_we_q   <= 1'b0;
      rf_a3_q   <= '0;
      rf_wd_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      funct3_q  <= funct3_d;
      addr_lo_q <= addr_lo_d;
      rf_we_q   <= rf_we_d;
      rf_a3_q   <= rf_a3_d;
      rf_wd_q   <= rf_wd_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_a3 = rf_a3_q;
  assign rf_wd = rf_wd_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_wb_unit.sv
// Scoreboard bench for wb_unit: driver pushes expected write beats (value and
// arrival cycle), an independent monitor pops and compares on done/err.
module tb_wb_unit;

  localparam int XLEN = 32;
  localparam int TO   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            wb_req;
  logic [4:0]      wb_rd;
  logic [1:0]      wb_src;
  logic [2:0]      wb_funct3;
  logic [1:0]      wb_addr_lo;
  logic [XLEN-1:0] alu_result, pc_plus4, imm, mem_rdata;
  logic            mem_rvalid;
  logic            rf_we, busy, done, err;
  logic [4:0]      rf_a3;
  logic [XLEN-1:0] rf_wd;

  wb_unit #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .wb_req(wb_req), .wb_rd(wb_rd), .wb_src(wb_src),
    .wb_funct3(wb_funct3), .wb_addr_lo(wb_addr_lo), .alu_result(alu_result),
    .pc_plus4(pc_plus4), .imm(imm), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_err;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    int unsigned at;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference load: shift the addressed lane down, mask, extend by type.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [31:0] v;
    int          sh;
    case (f3)
      3'b000, 3'b100: begin
        sh = 8 * int'(lo);
        v  = (w >> sh) & 32'hFF;
        if (f3 == 3'b000 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        sh = (int'(lo) >= 2) ? 16 : 0;
        v  = (w >> sh) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // Monitor: every done/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (done || err) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", {30'd0, done, err}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pulse_cycle", cyc, e.at);
          check("err", err, e.is_err);
          check("done", done, !e.is_err);
          check("rf_we", rf_we, e.we && !e.is_err);
          if (!e.is_err) begin
            check("rf_a3", rf_a3, e.a3);
            check("rf_wd", rf_wd, e.wd);
          end
        end
      end else if (rf_we) begin
        check("stray_rf_we", rf_we, 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_req();
    wb_req     = 1'($urandom_range(0, 1));
    wb_rd      = 5'($urandom);
    wb_src     = 2'($urandom);
    wb_funct3  = 3'($urandom);
    wb_addr_lo = 2'($urandom);
    alu_result = $urandom;
    pc_plus4   = $urandom;
    imm        = $urandom;
  endtask

  task automatic txn(input logic [1:0] src, input logic [4:0] rd, input logic [2:0] f3,
                     input logic [1:0] lo, input logic [31:0] val, input int delay);
    exp_t e;
    bit   timed_out;
    int   n_wait;
`ifdef WB_TIMEOUT_EN
    timed_out = (delay >= TO);
`else
    timed_out = 1'b0;
`endif
    n_wait = timed_out ? TO : delay;

    wb_req = 1'b1; wb_rd = rd; wb_src = src; wb_funct3 = f3; wb_addr_lo = lo;
    alu_result = $urandom; pc_plus4 = $urandom; imm = $urandom;
    case (src)
      2'b00:   alu_result = val;
      2'b10:   pc_plus4   = val;
      2'b11:   imm        = val;
      default: ;
    endcase
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    e.is_err = 1'b0; e.we = (rd != 5'd0); e.a3 = rd;

    if (src != 2'b01) begin
      e.wd = val;
      e.at = cyc + 1;
      sb.push_back(e);
      tick();
    end else begin
      tick();
      check("busy_wait_mem", busy, 1'b1);
      for (int d = 0; d < n_wait; d++) begin
        junk_req();
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (timed_out && d == n_wait - 1) begin
          e.is_err = 1'b1;
          e.at     = cyc + 1;
          sb.push_back(e);
        end
        tick();
      end
      if (timed_out) begin
        wb_req = 1'b0;
        mem_rvalid = 1'b0;
        return;
      end
      junk_req();
      mem_rvalid = 1'b1;
      mem_rdata  = val;
      e.wd = ref_load(f3, lo, val);
      e.at = cyc + 1;
      sb.push_back(e);
      tick();
    end
    // Write cycle: still busy, so this request and rvalid must be ignored.
    check("busy_write", busy, 1'b1);
    junk_req();
    wb_req     = 1'b1;
    mem_rvalid = 1'($urandom_range(0, 1));
    tick();
    wb_req     = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wb_req = 1'b0; wb_rd = '0; wb_src = '0; wb_funct3 = '0; wb_addr_lo = '0;
    alu_result = '0; pc_plus4 = '0; imm = '0; mem_rdata = '0; mem_rvalid = 1'b0;
    #3;
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_rf_a3", rf_a3, 5'd0);
    check("rst_rf_wd", rf_wd, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();

    txn(2'b00, 5'd5, 3'b000, 2'd0, 32'hDEAD_BEEF, 0);
    txn(2'b10, 5'd0, 3'b000, 2'd0, 32'h0000_0104, 0);
    txn(2'b01, 5'd7, 3'b000, 2'd3, 32'h80FF_1234, 3);
    txn(2'b01, 5'd9, 3'b101, 2'd2, 32'h8001_0000, 1);
    txn(2'b01, 5'd3, 3'b001, 2'd1, 32'h1234_8000, 0);
    txn(2'b11, 5'd31, 3'b000, 2'd0, 32'hABCD_0000, 0);
    txn(2'b01, 5'd4, 3'b010, 2'd1, 32'hCAFE_F00D, 6);

    // Async reset while waiting on memory: outputs drop at once, nothing completes.
    wb_req = 1'b1; wb_rd = 5'd12; wb_src = 2'b01; wb_funct3 = 3'b010; wb_addr_lo = 2'd0;
    tick();
    wb_req = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_rf_we", rf_we, 1'b0);
    check("midrst_rf_a3", rf_a3, 5'd0);
    check("midrst_rf_wd", rf_wd, 32'd0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_err", err, 1'b0);
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom;
    tick();
    mem_rvalid = 1'b0;
    tick();
    check("midrst_idle", busy, 1'b0);

    for (int i = 0; i < 250; i++) begin
      txn(2'($urandom), 5'($urandom), 3'($urandom), 2'($urandom), $urandom,
          $urandom_range(0, 6));
      repeat ($urandom_range(0, 2)) begin
        wb_req     = 1'b0;
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        tick();
      end
      mem_rvalid = 1'b0;
    end

    repeat (4) tick();
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
